invader_march_ctrl: RTL

Sequences the invader formation: decides when the block steps horizontally, when it drops a line, and when it reverses direction. Sits between the game-state FSM and the invader renderer/collision logic. Consumes the game state, a per-frame tick and the 20-bit alive mask. Produces the formation X offset, direction and the `invader_line` count that the game FSM compares against 14 for game over.

---
 rtl/space_invaders_pkg.sv | 9 +
 rtl/invader_march_ctrl_if.sv | 13 +
 rtl/invader_extent.sv | 24 ++
 rtl/invader_march_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: shared game-state and march encodings plus formation geometry.
package space_invaders_pkg;
  typedef enum logic [1:0] {BEGIN = 2'b00, CONT = 2'b01, WIN = 2'b10, GAMEOVER = 2'b11} game_state_t;
  typedef enum logic [2:0] {IDLE, WAIT, EVAL, STEP, DROP} march_state_t;
  localparam int COLS = 5;
  localparam int ROWS = 4;
  localparam int NUM_INVADERS = COLS * ROWS;
  localparam int GAMEOVER_LINE = 14;
endpackage

// File: rtl/invader_march_ctrl_if.sv
// invader_march_ctrl_if: game-FSM side (master) to march controller (slave) signals.
interface invader_march_ctrl_if import space_invaders_pkg::*; ();
  logic frame_tick;
  game_state_t game_state;
  logic [NUM_INVADERS-1:0] alive_mask;
  logic [9:0] x_off;
  logic dir_left;
  logic [3:0] invader_line;
  logic step_pulse;
  logic anim_frame;
  modport master(output frame_tick, game_state, alive_mask, input x_off, dir_left, invader_line, step_pulse, anim_frame);
  modport slave(input frame_tick, game_state, alive_mask, output x_off, dir_left, invader_line, step_pulse, anim_frame);
endinterface

// File: rtl/invader_extent.sv
// invader_extent: leftmost/rightmost occupied column and population of the alive mask.
module invader_extent import space_invaders_pkg::*; (
  input  logic [NUM_INVADERS-1:0] alive_mask,
  output logic [2:0] lcol,
  output logic [2:0] rcol,
  output logic [4:0] alive_count,
  output logic any_alive
);
  logic [COLS-1:0] col_any;
  always_comb begin
    col_any = '0;
    alive_count = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        col_any[c] = col_any[c] | alive_mask[r*COLS+c];
        alive_count = alive_count + 5'(alive_mask[r*COLS+c]);
      end
    lcol = '0;
    rcol = '0;
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lcol = 3'(c);
    for (int c = 0; c < COLS; c++) if (col_any[c]) rcol = 3'(c);
  end
  assign any_alive = |alive_mask;
endmodule

// File: rtl/invader_march_ctrl.sv
// invader_march_ctrl: paces the formation's steps, drops and reversals from the frame tick.
// Optional MARCH_ANIM_EN: anim_frame toggles on every step_pulse, otherwise tied to 0.
module invader_march_ctrl import space_invaders_pkg::*; #(
  parameter int COL_PITCH  = 16,
  parameter int INV_W      = 12,
  parameter int FIELD_W    = 640,
  parameter int X_INIT     = 64,
  parameter int STEP_PX    = 4,
  parameter int MAX_PERIOD = 32,
  parameter int MIN_PERIOD = 2,
  parameter int SPEEDUP    = 1
) (
  input logic clk,
  input logic reset,
  invader_march_ctrl_if.slave bus
);
  march_state_t state;
  logic [5:0] cnt, period;
  logic [2:0] lcol, rcol;
  logic [4:0] alive_count;
  logic any_alive, expire, drop;
  logic [10:0] left_edge, right_edge;
  int p;
  invader_extent u_ext (.alive_mask(bus.alive_mask), .lcol, .rcol, .alive_count, .any_alive);
  always_comb begin
    p = MAX_PERIOD - SPEEDUP * (NUM_INVADERS - int'(alive_count));
    period = 6'(p < MIN_PERIOD ? MIN_PERIOD : p);
  end
  assign expire = 7'(cnt) + 7'd1 >= 7'(period);
  assign left_edge = 11'(bus.x_off) + 11'(lcol) * 11'(COL_PITCH);
  assign right_edge = 11'(bus.x_off) + 11'(rcol) * 11'(COL_PITCH) + 11'(INV_W - 1);
  // The x_off term keeps the origin non-negative once the left columns are all dead
  assign drop = bus.dir_left ? (left_edge < 11'(STEP_PX) || bus.x_off < 10'(STEP_PX))
                             : (right_edge + 11'(STEP_PX) > 11'(FIELD_W - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.x_off <= 10'(X_INIT);
      bus.dir_left <= 1'b0;
      bus.invader_line <= '0;
      bus.step_pulse <= 1'b0;
    end else if (bus.game_state != CONT) begin
      state <= IDLE;
      cnt <= '0;
      bus.step_pulse <= 1'b0;
      if (bus.game_state == BEGIN) begin
        bus.x_off <= 10'(X_INIT);
        bus.dir_left <= 1'b0;
        bus.invader_line <= '0;
      end
    end else begin
      bus.step_pulse <= state == STEP || state == DROP;
      unique case (state)
        IDLE: state <= WAIT;
        WAIT: if (bus.frame_tick) begin
          cnt <= expire ? '0 : cnt + 6'd1;
          state <= expire ? EVAL : WAIT;
        end
        EVAL: state <= !any_alive ? WAIT : drop ? DROP : STEP;
        STEP: begin
          bus.x_off <= bus.dir_left ? bus.x_off - 10'(STEP_PX) : bus.x_off + 10'(STEP_PX);
          state <= WAIT;
        end
        DROP: begin
          bus.dir_left <= ~bus.dir_left;
          bus.invader_line <= bus.invader_line + 4'(bus.invader_line != 4'hF);
          state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef MARCH_ANIM_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.anim_frame <= 1'b0;
    else if (bus.game_state == BEGIN) bus.anim_frame <= 1'b0;
    else if (bus.game_state == CONT && (state == STEP || state == DROP)) bus.anim_frame <= ~bus.anim_frame;
`else
  assign bus.anim_frame = 1'b0;
`endif
endmodule
